// File: rtl/multi_tone_generator.sv
// Multi-channel square-wave tone generator with runtime half-periods,
// per-channel pitch sweep and a registered popcount mix output.
module multi_tone_generator #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 16,
    parameter int STEP_W    = 8,
    parameter int SWEEP_DIV = 256
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [3:0]                         cfg_chan,
    input  logic                               cfg_enable,
    input  logic [CNT_W-1:0]                   cfg_half_period,
    input  logic [STEP_W-1:0]                  cfg_step,
    output logic [CHANNELS-1:0]                tone_out,
    output logic [$clog2(CHANNELS+1)-1:0]      mix_out
);

    localparam int MIX_W = $clog2(CHANNELS + 1);
    localparam int PRE_W = $clog2(SWEEP_DIV);
    localparam int SUM_W = ((CNT_W + 1 > STEP_W) ? CNT_W + 1 : STEP_W) + 1;
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((2 ** CNT_W) - 1);
    localparam logic signed [SUM_W-1:0] ONE  = SUM_W'(1);

    logic              hold_valid;
    logic [3:0]        hold_chan;
    logic              hold_en;
    logic [CNT_W-1:0]  hold_hp;
    logic [STEP_W-1:0] hold_step;
    logic [PRE_W-1:0]  pres;
    logic              tick;
    logic [MIX_W-1:0]  ones;

    assign cfg_ready = !hold_valid;
    assign tick      = (pres == PRE_W'(SWEEP_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_chan  <= '0;
            hold_en    <= 1'b0;
            hold_hp    <= '0;
            hold_step  <= '0;
        end else if (hold_valid) begin
            hold_valid <= 1'b0;
        end else if (cfg_valid) begin
            hold_valid <= 1'b1;
            hold_chan  <= cfg_chan;
            hold_en    <= cfg_enable;
            hold_hp    <= cfg_half_period;
            hold_step  <= cfg_step;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pres <= '0;
        end else if (tick) begin
            pres <= '0;
        end else begin
            pres <= pres + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0]         base;
        logic [CNT_W-1:0]         shadow;
        logic [CNT_W-1:0]         active;
        logic [CNT_W-1:0]         count;
        logic [STEP_W-1:0]        step;
        logic                     en;
        logic                     tone;
        logic                     apply;
        logic                     last;
        logic                     wrap;
        logic signed [SUM_W-1:0]  sum;

        assign apply = hold_valid && (hold_chan == 4'(i));
        assign last  = (count == active - CNT_W'(1));
        assign sum   = SUM_W'($signed({1'b0, shadow})) + SUM_W'($signed(step));
        assign wrap  = (sum > MAXV) || (sum < ONE);
        assign tone_out[i] = tone;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                base   <= '0;
                shadow <= '0;
                active <= '0;
                count  <= '0;
                step   <= '0;
                en     <= 1'b0;
                tone   <= 1'b0;
            end else begin
                // config beats a sweep tick landing in the same cycle
                if (apply) begin
                    base   <= hold_hp;
                    shadow <= hold_hp;
                    step   <= hold_step;
                    en     <= hold_en;
                end else if (tick && en && (step != '0)) begin
                    shadow <= wrap ? base : sum[CNT_W-1:0];
                end
                // active only reloads at a toggle or while idle
                if (!en || (active == '0)) begin
                    tone   <= 1'b0;
                    count  <= '0;
                    active <= shadow;
                end else if (last) begin
                    tone   <= ~tone;
                    count  <= '0;
                    active <= shadow;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ones = ones + MIX_W'(tone_out[k]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mix_out <= '0;
        end else begin
            mix_out <= ones;
        end
    end

endmodule

// File: tb/tb_multi_tone_generator.sv
// Self-checking bench for multi_tone_generator: behavioural model,
// per-cycle compare, directed scenarios and randomized config traffic.
module tb_multi_tone_generator;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int STW  = 8;
    localparam int DIV  = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic           clock = 1'b0;
    logic           reset_n = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [3:0]     cfg_chan = '0;
    logic           cfg_enable = 1'b0;
    logic [CW-1:0]  cfg_half_period = '0;
    logic [STW-1:0] cfg_step = '0;
    logic [CH-1:0]  tone_out;
    logic [2:0]     mix_out;

    int n_vec = 0;
    int n_bad = 0;
    int mq[$];

    multi_tone_generator #(
        .CHANNELS(CH), .CNT_W(CW), .STEP_W(STW), .SWEEP_DIV(DIV)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_enable(cfg_enable),
        .cfg_half_period(cfg_half_period),
        .cfg_step(cfg_step),
        .tone_out(tone_out),
        .mix_out(mix_out)
    );

    always #5 clock = ~clock;

    // behavioural model state, one int per quantity per channel
    int m_en[CH], m_base[CH], m_sh[CH], m_act[CH];
    int m_cnt[CH], m_step[CH], m_tone[CH];
    int m_pres, m_mix;
    bit m_hv;
    int m_hch, m_hen, m_hhp, m_hst;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int popc(input logic [CH-1:0] v);
        int c = 0;
        for (int i = 0; i < CH; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int model_tones();
        int t = 0;
        for (int i = 0; i < CH; i++) t += m_tone[i] << i;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_en[i] = 0; m_base[i] = 0; m_sh[i] = 0; m_act[i] = 0;
            m_cnt[i] = 0; m_step[i] = 0; m_tone[i] = 0;
        end
        m_pres = 0; m_mix = 0; m_hv = 0;
        m_hch = 0; m_hen = 0; m_hhp = 0; m_hst = 0;
    endtask

    task automatic model_clock();
        int nt[CH], nc[CH], na[CH], ns[CH];
        int s, ones;
        bit tick;
        tick = (m_pres == DIV - 1);
        ones = 0;
        for (int i = 0; i < CH; i++) ones += m_tone[i];
        for (int i = 0; i < CH; i++) begin
            nt[i] = m_tone[i]; nc[i] = m_cnt[i];
            na[i] = m_act[i];  ns[i] = m_sh[i];
            if (m_en[i] == 0 || m_act[i] == 0) begin
                nt[i] = 0; nc[i] = 0; na[i] = m_sh[i];
            end else if (m_cnt[i] == m_act[i] - 1) begin
                nt[i] = 1 - m_tone[i]; nc[i] = 0; na[i] = m_sh[i];
            end else begin
                nc[i] = m_cnt[i] + 1;
            end
            if (m_hv && m_hch == i) begin
                ns[i] = m_hhp; m_base[i] = m_hhp;
                m_step[i] = m_hst; m_en[i] = m_hen;
            end else if (tick && m_en[i] != 0 && m_step[i] != 0) begin
                s = m_sh[i] + m_step[i];
                ns[i] = (s > MAXV || s < 1) ? m_base[i] : s;
            end
        end
        for (int i = 0; i < CH; i++) begin
            m_tone[i] = nt[i]; m_cnt[i] = nc[i];
            m_act[i] = na[i];  m_sh[i] = ns[i];
        end
        m_mix = ones;
        if (m_hv) begin
            m_hv = 0;
        end else if (cfg_valid) begin
            m_hv = 1;
            m_hch = int'(cfg_chan);
            m_hen = int'(cfg_enable);
            m_hhp = int'(cfg_half_period);
            m_hst = int'($signed(cfg_step));
        end
        m_pres = tick ? 0 : m_pres + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_clock();
        end
    end

    // per-cycle compare of every output against the model
    initial begin
        logic [CH-1:0] prev;
        bit prev_ok;
        prev = '0;
        prev_ok = 0;
        forever begin
            @(negedge clock);
            chk("tone_out", int'(tone_out), model_tones());
            chk("mix_out", int'(mix_out), m_mix);
            chk("cfg_ready", int'(cfg_ready), int'(!m_hv));
            if (prev_ok && reset_n) chk("mix_lag", int'(mix_out), popc(prev));
            prev = tone_out;
            prev_ok = reset_n;
        end
    end

    // ch0 segment-length monitor
    initial begin
        int run;
        logic pv;
        run = 0;
        pv = 1'b0;
        forever begin
            @(negedge clock);
            if (tone_out[0] !== pv) begin
                mq.push_back(run);
                run = 1;
                pv = tone_out[0];
            end else begin
                run++;
            end
        end
    end

    task automatic cfg_write(input int ch, input bit en, input int hp,
                             input int st, input int sync);
        int k;
        k = 0;
        @(negedge clock);
        while ((m_hv || (sync >= 0 && m_pres != sync)) && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) chk("cfg_write_wait", k, 0);
        cfg_valid = 1'b1;
        cfg_chan = 4'(ch);
        cfg_enable = en;
        cfg_half_period = CW'(hp);
        cfg_step = STW'(st);
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (m_pres != 0 && k < 20);
        if (k >= 20) chk("tick_wait", k, 0);
    endtask

    initial begin
        int n, k;
        int exp4[5];
        int exp5[3];
        int steps[8];
        exp4 = '{7, 4, 1, 10, 7};
        exp5 = '{15, 14, 15};
        steps = '{0, 0, 0, 1, -1, 2, -3, 5};

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_tone", int'(tone_out), 0);
        chk("rst_mix", int'(mix_out), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        reset_n = 1'b1;

        // hp=6: 6-cycle halves
        mq.delete();
        cfg_write(0, 1, 6, 0, -1);
        repeat (40) @(negedge clock);
        chk("t1_nseg", int'(mq.size() >= 3), 1);
        if (mq.size() >= 3) begin
            chk("t1_high", mq[1], 6);
            chk("t1_low", mq[2], 6);
        end

        // retune to hp=3 mid half-cycle
        n = mq.size();
        k = 0;
        while (mq.size() <= n && k < 50) begin
            @(posedge clock);
            k++;
        end
        chk("t2_sync", int'(k < 50), 1);
        mq.delete();
        cfg_write(0, 1, 3, 0, -1);
        repeat (30) @(negedge clock);
        chk("t2_nseg", int'(mq.size() >= 3), 1);
        if (mq.size() >= 3) begin
            chk("t2_finish6", mq[0], 6);
            chk("t2_half3a", mq[1], 3);
            chk("t2_half3b", mq[2], 3);
        end

        // back-to-back writes, last one to an absent channel
        @(negedge clock);
        cfg_valid = 1'b1; cfg_chan = 4'd1; cfg_enable = 1'b1;
        cfg_half_period = CW'(5); cfg_step = '0;
        chk("t3_rdy0", int'(cfg_ready), 1);
        @(negedge clock);
        chk("t3_rdy1", int'(cfg_ready), 0);
        @(negedge clock);
        cfg_chan = 4'd2; cfg_half_period = CW'(7);
        chk("t3_rdy2", int'(cfg_ready), 1);
        @(negedge clock);
        chk("t3_rdy3", int'(cfg_ready), 0);
        @(negedge clock);
        cfg_chan = 4'd7; cfg_half_period = CW'(1);
        chk("t3_rdy4", int'(cfg_ready), 1);
        @(negedge clock);
        chk("t3_rdy5", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        repeat (30) @(negedge clock);

        // downward sweep wrapping to base
        cfg_write(0, 1, 10, -3, 0);
        for (int j = 0; j < 5; j++) begin
            wait_tick();
            chk("t4_shadow", m_sh[0], exp4[j]);
        end

        // upward overflow, then config vs tick collision
        cfg_write(0, 1, 14, 1, 0);
        for (int j = 0; j < 3; j++) begin
            wait_tick();
            chk("t5_shadow", m_sh[0], exp5[j]);
        end
        cfg_write(0, 1, 9, 1, 2);
        @(negedge clock);
        chk("t5_cfg_wins", m_sh[0], 9);
        repeat (40) @(negedge clock);

        // all four channels, then async reset with a pending write
        for (int c = 0; c < CH; c++) cfg_write(c, 1, c + 2, 0, -1);
        repeat (60) @(negedge clock);
        @(negedge clock);
        cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_enable = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("t6_rst_tone", int'(tone_out), 0);
        chk("t6_rst_mix", int'(mix_out), 0);
        chk("t6_rst_ready", int'(cfg_ready), 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < CH; c++) cfg_write(c, 1, 2 * c + 1, 0, -1);
        repeat (30) @(negedge clock);

        // randomized config traffic
        repeat (1500) begin
            @(negedge clock);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_chan = 4'($urandom_range(0, 7));
            cfg_enable = ($urandom_range(0, 3) != 0);
            cfg_half_period = CW'($urandom_range(0, MAXV));
            cfg_step = STW'(steps[$urandom_range(0, 7)]);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        repeat (30) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
